// File: rtl/noc_pkg.sv
// Shared arbiter definitions: state encoding and one-hot/index conversion helpers.
// Helpers work on the widest legal port count; callers cast to their own width.
package noc_pkg;

    localparam int MAX_PORTS = 16;
    localparam int MAX_SELW  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [MAX_PORTS-1:0] onehot_of(input logic [MAX_SELW-1:0] idx);
        logic [MAX_PORTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [MAX_SELW-1:0] index_of(input logic [MAX_PORTS-1:0] oh);
        logic [MAX_SELW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = MAX_SELW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_packet_arbiter_if.sv
// Request/grant bundle between the input ports, the arbiter and the downstream crossbar.
// master drives requests and ready; slave (the arbiter) drives grant and status.
interface rr_packet_arbiter_if #(
    parameter int PORT_N = 5
);
    localparam int SELW = $clog2(PORT_N);

    logic [PORT_N-1:0] vld_i;
    logic [PORT_N-1:0] last_i;
    logic              out_rdy_i;
    logic [PORT_N-1:0] gnt_o;
    logic [SELW-1:0]   sel_o;
    logic              out_vld_o;
    logic              locked_o;
    logic              timeout_o;

    modport master (
        output vld_i, last_i, out_rdy_i,
        input  gnt_o, sel_o, out_vld_o, locked_o, timeout_o
    );

    modport slave (
        input  vld_i, last_i, out_rdy_i,
        output gnt_o, sel_o, out_vld_o, locked_o, timeout_o
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at PORT_N-1.
// Produces the one-hot grant and its binary index (index 0 when nothing is requested).
module rr_pick
    import noc_pkg::*;
#(
    parameter  int PORT_N = 5,
    localparam int SELW   = $clog2(PORT_N)
) (
    input  logic [PORT_N-1:0] req,
    input  logic [SELW-1:0]   ptr,
    output logic [PORT_N-1:0] gnt,
    output logic [SELW-1:0]   idx
);

    int              pos;
    logic [SELW-1:0] cand;
    logic            found;

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int i = 0; i < PORT_N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= PORT_N) pos = pos - PORT_N;
            cand = SELW'(pos);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
            end
        end
        idx = SELW'(index_of(MAX_PORTS'(gnt)));
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: grants one port and holds the output until that packet's tail.
// Optional lock watchdog built when PKT_ARB_WATCHDOG_EN is defined.
module rr_packet_arbiter
    import noc_pkg::*;
#(
    parameter int PORT_N      = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    rr_packet_arbiter_if.slave  bus
);

    localparam int SELW = $clog2(PORT_N);

    arb_state_e        state;
    logic [SELW-1:0]   rr_ptr;
    logic [SELW-1:0]   owner;

    logic [PORT_N-1:0] pick_gnt;
    logic [SELW-1:0]   pick_sel;
    logic [PORT_N-1:0] gnt;
    logic [SELW-1:0]   sel;
    logic              out_vld;
    logic              xfer;
    logic              tail;
    logic              wd_hit;

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] v);
        return (int'(v) == PORT_N - 1) ? '0 : v + 1'b1;
    endfunction

    rr_pick #(.PORT_N(PORT_N)) u_pick (
        .req (bus.vld_i),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_sel)
    );

    // Outputs are forced low while reset is held, even though the idle grant is combinational.
    always_comb begin
        gnt     = '0;
        sel     = '0;
        out_vld = 1'b0;
        if (rst_ni) begin
            if (state == IDLE) begin
                gnt     = pick_gnt;
                sel     = pick_sel;
                out_vld = |bus.vld_i;
            end else begin
                gnt     = PORT_N'(onehot_of(MAX_SELW'(owner)));
                sel     = owner;
                out_vld = bus.vld_i[owner];
            end
        end
        xfer = out_vld & bus.out_rdy_i;
        tail = xfer & bus.last_i[sel];
    end

`ifdef PKT_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYC);

    logic [WDW-1:0] wdog;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog <= '0;
        end else if (state == IDLE) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end

    // A tail on the limit cycle wins over the timeout.
    assign wd_hit = (state == LOCKED) && (wdog == WDW'(TIMEOUT_CYC - 1)) && !tail;
`else
    assign wd_hit = 1'b0;
`endif

    // NOTE: every control register has an async reset so a reset mid-packet drops the lock at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (bus.last_i[sel]) begin
                            rr_ptr <= wrap_inc(sel);
                        end else begin
                            owner <= sel;
                            state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (tail || wd_hit) begin
                        state  <= IDLE;
                        rr_ptr <= wrap_inc(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o     = gnt;
    assign bus.sel_o     = sel;
    assign bus.out_vld_o = out_vld;
    assign bus.locked_o  = (state == LOCKED);
    assign bus.timeout_o = wd_hit;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter: a 5-port instance (TIMEOUT_CYC=8) and a 3-port instance.
// Expectations are hand-computed; watchdog expectations follow PKT_ARB_WATCHDOG_EN.
module tb_rr_packet_arbiter;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk = ~clk;

    rr_packet_arbiter_if #(.PORT_N(5)) if5 ();
    rr_packet_arbiter_if #(.PORT_N(3)) if3 ();

    rr_packet_arbiter #(.PORT_N(5), .TIMEOUT_CYC(8)) dut5 (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (if5)
    );

    rr_packet_arbiter #(.PORT_N(3), .TIMEOUT_CYC(8)) dut3 (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (if3)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [4:0] vld;
        logic [4:0] last;
        logic       rdy;
        logic [4:0] gnt;
        logic [2:0] sel;
        logic       ovld;
        logic       locked;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive5(input logic [4:0] vld, input logic [4:0] last, input logic rdy);
        if5.vld_i     = vld;
        if5.last_i    = last;
        if5.out_rdy_i = rdy;
        #1;
    endtask

    task automatic drive3(input logic [2:0] vld, input logic [2:0] last, input logic rdy);
        if3.vld_i     = vld;
        if3.last_i    = last;
        if3.out_rdy_i = rdy;
        #1;
    endtask

    task automatic expect5(input string n, input logic [4:0] g, input logic [2:0] s,
                           input logic v, input logic l, input logic t);
        check({n, ".gnt"},     32'(if5.gnt_o),     32'(g));
        check({n, ".sel"},     32'(if5.sel_o),     32'(s));
        check({n, ".out_vld"}, 32'(if5.out_vld_o), 32'(v));
        check({n, ".locked"},  32'(if5.locked_o),  32'(l));
        check({n, ".timeout"}, 32'(if5.timeout_o), 32'(t));
    endtask

    task automatic expect3(input string n, input logic [2:0] g, input logic [1:0] s,
                           input logic v, input logic l);
        check({n, ".gnt"},     32'(if3.gnt_o),     32'(g));
        check({n, ".sel"},     32'(if3.sel_o),     32'(s));
        check({n, ".out_vld"}, 32'(if3.out_vld_o), 32'(v));
        check({n, ".locked"},  32'(if3.locked_o),  32'(l));
    endtask

    initial begin
        vecs[0]  = '{"rr_a",      5'b10100, 5'b11111, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0};
        vecs[1]  = '{"rr_b",      5'b10100, 5'b11111, 1'b1, 5'b10000, 3'd4, 1'b1, 1'b0};
        vecs[2]  = '{"rr_c",      5'b10100, 5'b11111, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0};
        vecs[3]  = '{"none",      5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{"wrap0",     5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b0};
        vecs[5]  = '{"pkt_f1",    5'b01010, 5'b01000, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b0};
        vecs[6]  = '{"pkt_f2",    5'b01010, 5'b01000, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1};
        vecs[7]  = '{"pkt_f3",    5'b01010, 5'b01000, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1};
        vecs[8]  = '{"pkt_f4",    5'b01010, 5'b01010, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1};
        vecs[9]  = '{"after_pkt", 5'b01010, 5'b01000, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0};
        vecs[10] = '{"stall_a",   5'b00011, 5'b00011, 1'b0, 5'b00001, 3'd0, 1'b1, 1'b0};
        vecs[11] = '{"stall_b",   5'b00010, 5'b00000, 1'b0, 5'b00010, 3'd1, 1'b1, 1'b0};
        vecs[12] = '{"lock0",     5'b00001, 5'b00000, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b0};
        vecs[13] = '{"bubble1",   5'b11110, 5'b11110, 1'b1, 5'b00001, 3'd0, 1'b0, 1'b1};
        vecs[14] = '{"bubble2",   5'b11110, 5'b11110, 1'b1, 5'b00001, 3'd0, 1'b0, 1'b1};
        vecs[15] = '{"tail0",     5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1};
        vecs[16] = '{"no_rdy",    5'b11111, 5'b11111, 1'b0, 5'b00010, 3'd1, 1'b1, 1'b0};

        // Reset held with every port requesting: all outputs must stay low.
        drive3(3'b111, 3'b000, 1'b1);
        drive5(5'b11111, 5'b00000, 1'b1);
        expect5("rst_hold", 5'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        expect3("rst_hold3", 3'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        expect5("rst_edge", 5'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        drive3(3'b000, 3'b000, 1'b1);
        drive5(5'b00000, 5'b00000, 1'b1);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive5(vecs[i].vld, vecs[i].last, vecs[i].rdy);
            expect5(vecs[i].name, vecs[i].gnt, vecs[i].sel, vecs[i].ovld, vecs[i].locked, 1'b0);
            @(negedge clk);
        end

        // rr_ptr=1: lock port 2 and never send its tail.
        drive5(5'b00100, 5'b00000, 1'b1);
        expect5("wd_lock", 5'b00100, 3'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
`ifdef PKT_ARB_WATCHDOG_EN
        for (int k = 1; k <= 8; k++) begin
            drive5(5'b00100, 5'b00000, 1'b1);
            check($sformatf("wd_cyc%0d.locked", k), 32'(if5.locked_o), 32'd1);
            check($sformatf("wd_cyc%0d.timeout", k), 32'(if5.timeout_o), (k == 8) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        drive5(5'b00100, 5'b00000, 1'b1);
        expect5("wd_idle", 5'b00100, 3'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        // Tail lands exactly on the limit cycle: it must win over the timeout.
        for (int k = 1; k <= 8; k++) begin
            drive5(5'b00100, (k == 8) ? 5'b00100 : 5'b00000, 1'b1);
            check($sformatf("wd_race%0d.timeout", k), 32'(if5.timeout_o), 32'd0);
            check($sformatf("wd_race%0d.locked", k), 32'(if5.locked_o), 32'd1);
            @(negedge clk);
        end
`else
        for (int k = 1; k <= 100; k++) begin
            drive5(5'b00100, 5'b00000, 1'b1);
            check($sformatf("nowd_cyc%0d.locked", k), 32'(if5.locked_o), 32'd1);
            check($sformatf("nowd_cyc%0d.timeout", k), 32'(if5.timeout_o), 32'd0);
            @(negedge clk);
        end
        drive5(5'b00100, 5'b00100, 1'b1);
        expect5("nowd_tail", 5'b00100, 3'd2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
`endif
        drive5(5'b00000, 5'b00000, 1'b1);
        expect5("wd_done", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // rr_ptr=3: lock port 3, then pull reset mid-packet.
        drive5(5'b11111, 5'b00000, 1'b1);
        expect5("rst_lock", 5'b01000, 3'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive5(5'b11111, 5'b00000, 1'b1);
        expect5("rst_locked", 5'b01000, 3'd3, 1'b1, 1'b1, 1'b0);
        rst_ni = 1'b0;
        #1;
        expect5("rst_async", 5'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        expect5("rst_held", 5'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        drive5(5'b11111, 5'b11111, 1'b1);
        expect5("rst_restart", 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive5(5'b00000, 5'b00000, 1'b0);

        // Three-port instance: non-power-of-two wrap of the search and of rr_ptr.
        drive3(3'b010, 3'b010, 1'b1);
        expect3("p3_a", 3'b010, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        drive3(3'b011, 3'b011, 1'b1);
        expect3("p3_wrap", 3'b001, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        drive3(3'b111, 3'b010, 1'b1);
        expect3("p3_after", 3'b010, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        drive3(3'b100, 3'b100, 1'b1);
        expect3("p3_top", 3'b100, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        drive3(3'b111, 3'b111, 1'b0);
        expect3("p3_zero", 3'b001, 2'd0, 1'b1, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
